accum_seq_ctrl: RTL and testbench

- Sequencer that drives one dot-product + accum datapath for a matrix-vector multiply.
- On a start command it issues matrix/vector memory reads: num_words chunk reads per output row, for num_rows rows.
- It generates the accum first/last/ivalid tags, delayed to line up with the memory + dot-product pipeline.
- It reports busy/done to the top-level instruction decoder.

---
 rtl/accum_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_accum_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_seq_ctrl.sv
// ---------------------------------------------------------------------------
// accum_seq_ctrl
//
// Sequencer for one dot-product + accumulate datapath in a matrix-vector
// multiply. A start command latches the operand bases and the shape. The block
// then issues num_words chunk reads per output row, for num_rows rows, to the
// vector and matrix memories. For every read it generates an accumulator tag
// {valid, first, last}. The tag is delayed by PIPE_LAT cycles so it reaches
// the accumulator together with the matching dot-product result.
//
// Optional build macro: ACCUM_SEQ_CTRL_PERF_EN adds the perf_busy_cycles and
// perf_stall_cycles performance counters.
//
// Parameters
//   ADDRW     width of memory addresses and of the num_words/num_rows fields
//   PIPE_LAT  cycles from mem_ren high to the matching result at the accum
//             data input (>= 1)
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   start              one-cycle command pulse, accepted only in IDLE
//   vec_base           first vector-memory address
//   mat_base           first matrix-memory address
//   num_words          chunks per row
//   num_rows           output rows
//   stall              downstream almost-full; pauses issue
//   vec_raddr          vector memory read address (registered)
//   mat_raddr          matrix memory read address (registered)
//   mem_ren            read enable for both memories (registered)
//   accum_ivalid       accumulator input valid
//   accum_first        accumulator first-of-row
//   accum_last         accumulator last-of-row
//   busy               high in ISSUE and DRAIN
//   done               one-cycle completion pulse
//   perf_busy_cycles   (optional) count of busy cycles, saturating
//   perf_stall_cycles  (optional) count of stalled ISSUE cycles, saturating
// ---------------------------------------------------------------------------
module accum_seq_ctrl #(
   parameter int ADDRW    = 9,
   parameter int PIPE_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDRW-1:0] vec_base,
   input  logic [ADDRW-1:0] mat_base,
   input  logic [ADDRW-1:0] num_words,
   input  logic [ADDRW-1:0] num_rows,
   input  logic             stall,
   output logic [ADDRW-1:0] vec_raddr,
   output logic [ADDRW-1:0] mat_raddr,
   output logic             mem_ren,
   output logic             accum_ivalid,
   output logic             accum_first,
   output logic             accum_last,
   output logic             busy,
   output logic             done
`ifdef ACCUM_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]      perf_busy_cycles,
   output logic [31:0]      perf_stall_cycles
`endif
);

   localparam int DW = $clog2(PIPE_LAT) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t           state;

   // Latched command fields. The matrix base only seeds mat_ptr, because rows
   // are contiguous and a running pointer covers mat_base + r*num_words + w.
   logic [ADDRW-1:0] vb_q;
   logic [ADDRW-1:0] nw_q;
   logic [ADDRW-1:0] nr_q;

   logic [ADDRW-1:0] w;
   logic [ADDRW-1:0] r;
   logic [ADDRW-1:0] mat_ptr;
   logic [DW-1:0]    dcnt;

   // Tag pipe. Stage 0 is loaded on the same edge as mem_ren, so stage k holds
   // the tag of the read that was visible on mem_ren k cycles ago. Stage
   // PIPE_LAT therefore lines up with the dot-product result.
   logic [PIPE_LAT:0] vld_pipe;
   logic [PIPE_LAT:0] fst_pipe;
   logic [PIPE_LAT:0] lst_pipe;

   logic issue_now;
   logic last_w;
   logic last_r;
   logic zero_cmd;

   always_comb begin
      issue_now = (state == ISSUE) && !stall;
      last_w    = (w == nw_q - ADDRW'(1));
      last_r    = (r == nr_q - ADDRW'(1));
      zero_cmd  = (num_words == '0) || (num_rows == '0);
   end

   // ------------------------------------------------------------------------
   // Control FSM and registered memory-side outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vb_q      <= '0;
         nw_q      <= '0;
         nr_q      <= '0;
         w         <= '0;
         r         <= '0;
         mat_ptr   <= '0;
         dcnt      <= '0;
         vec_raddr <= '0;
         mat_raddr <= '0;
         mem_ren   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         mem_ren <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vb_q    <= vec_base;
                  nw_q    <= num_words;
                  nr_q    <= num_rows;
                  w       <= '0;
                  r       <= '0;
                  mat_ptr <= mat_base;
                  // An empty command skips straight to the done pulse.
                  if (zero_cmd) begin
                     state <= FIN;
                     busy  <= 1'b0;
                  end else begin
                     state <= ISSUE;
                     busy  <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               // On stall, counters, pointer and address outputs all hold.
               if (!stall) begin
                  mem_ren   <= 1'b1;
                  vec_raddr <= vb_q + w;
                  mat_raddr <= mat_ptr;
                  mat_ptr   <= mat_ptr + ADDRW'(1);
                  if (last_w) begin
                     w <= '0;
                     r <= r + ADDRW'(1);
                     if (last_r) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                     end
                  end else begin
                     w <= w + ADDRW'(1);
                  end
               end
            end

            DRAIN: begin
               // The final read is on mem_ren in the first DRAIN cycle. After
               // PIPE_LAT cycles its tag is at the pipe output, and done
               // follows one cycle later.
               if (dcnt == DW'(PIPE_LAT - 1)) begin
                  state <= FIN;
                  busy  <= 1'b0;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end

            FIN: begin
               done  <= 1'b1;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Tag pipe: always advances. Stalled and idle cycles push invalid tags.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         fst_pipe <= '0;
         lst_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[PIPE_LAT-1:0], issue_now};
         fst_pipe <= {fst_pipe[PIPE_LAT-1:0], issue_now && (w == '0)};
         lst_pipe <= {lst_pipe[PIPE_LAT-1:0], issue_now && last_w};
      end
   end

   assign accum_ivalid = vld_pipe[PIPE_LAT];
   assign accum_first  = fst_pipe[PIPE_LAT];
   assign accum_last   = lst_pipe[PIPE_LAT];

`ifdef ACCUM_SEQ_CTRL_PERF_EN
   // ------------------------------------------------------------------------
   // Performance counters. They clear on a start accept and hold after done.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else if (state == IDLE && start) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         if (state == ISSUE && stall && perf_stall_cycles != 32'hFFFF_FFFF)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accum_seq_ctrl
//
// Directed bench for accum_seq_ctrl (ADDRW=9, PIPE_LAT=4). Each command is
// driven on a falling edge. A negedge monitor logs every read, every valid
// accumulator tag and the done pulse against a free-running cycle count. The
// logs are then compared to hand-derived cycle offsets measured from the cycle
// in which start was high.
// ---------------------------------------------------------------------------
module tb_accum_seq_ctrl;
   localparam int ADDRW    = 9;
   localparam int PIPE_LAT = 4;
   localparam int AMOD     = 1 << ADDRW;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [ADDRW-1:0] vec_base, mat_base, num_words, num_rows;
   logic             stall;
   logic [ADDRW-1:0] vec_raddr, mat_raddr;
   logic             mem_ren, accum_ivalid, accum_first, accum_last, busy, done;
`ifdef ACCUM_SEQ_CTRL_PERF_EN
   logic [31:0]      perf_busy_cycles, perf_stall_cycles;
`endif

   accum_seq_ctrl #(.ADDRW(ADDRW), .PIPE_LAT(PIPE_LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .vec_base     (vec_base),
      .mat_base     (mat_base),
      .num_words    (num_words),
      .num_rows     (num_rows),
      .stall        (stall),
      .vec_raddr    (vec_raddr),
      .mat_raddr    (mat_raddr),
      .mem_ren      (mem_ren),
      .accum_ivalid (accum_ivalid),
      .accum_first  (accum_first),
      .accum_last   (accum_last),
      .busy         (busy),
      .done         (done)
`ifdef ACCUM_SEQ_CTRL_PERF_EN
      ,
      .perf_busy_cycles  (perf_busy_cycles),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor logs
   int   ren_cyc[$], ren_vec[$], ren_mat[$];
   int   tag_cyc[$], tag_f[$], tag_l[$];
   int   done_n, done_cyc, done_busy;
   logic busy_h [4096];
   logic any_h  [4096];
   int   vec_h  [4096];
   int   mat_h  [4096];

   always @(negedge clk) begin
      busy_h[cyc % 4096] <= busy;
      any_h[cyc % 4096]  <= mem_ren | accum_ivalid | accum_first | accum_last |
                            busy | done | (|vec_raddr) | (|mat_raddr);
      vec_h[cyc % 4096]  <= int'(vec_raddr);
      mat_h[cyc % 4096]  <= int'(mat_raddr);
      if (mem_ren) begin
         ren_cyc.push_back(cyc);
         ren_vec.push_back(int'(vec_raddr));
         ren_mat.push_back(int'(mat_raddr));
      end
      if (accum_ivalid) begin
         tag_cyc.push_back(cyc);
         tag_f.push_back(int'(accum_first));
         tag_l.push_back(int'(accum_last));
      end
      if (done) begin
         done_n    = done_n + 1;
         done_cyc  = cyc;
         done_busy = int'(busy);
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int k;          // cycle in which start was high
   int exp_rel[$]; // expected mem_ren cycles, relative to k

   // Issue one command. Offsets i count cycles after the start cycle.
   // kick_at: re-pulse start with different config; rst_at: pulse reset.
   task automatic do_cmd(input int vb, input int mb, input int nw, input int nr,
                         input int st0, input int stn, input int kick_at,
                         input int rst_at, input int ncyc);
      ren_cyc.delete(); ren_vec.delete(); ren_mat.delete();
      tag_cyc.delete(); tag_f.delete();   tag_l.delete();
      done_n = 0; done_cyc = -1; done_busy = -1;
      @(negedge clk);
      vec_base  = ADDRW'(vb);
      mat_base  = ADDRW'(mb);
      num_words = ADDRW'(nw);
      num_rows  = ADDRW'(nr);
      start     = 1'b1;
      k         = cyc;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         start = (i == kick_at);
         if (i == kick_at) begin
            vec_base  = ADDRW'(vb + 100);
            mat_base  = ADDRW'(mb + 50);
            num_words = ADDRW'(7);
            num_rows  = ADDRW'(9);
         end
         stall = (i >= st0) && (i < st0 + stn);
         rst   = (i == rst_at);
      end
      start = 1'b0;
      stall = 1'b0;
      rst   = 1'b0;
   endtask

   // Compare the logs against a full nw x nr sequence whose reads land on k+exp_rel[i].
   task automatic check_seq(input string nm, input int vb, input int mb,
                            input int nw, input int nr);
      int n;
      n = nw * nr;
      chk({nm, "_nren"}, ren_cyc.size(), n);
      for (int i = 0; i < n && i < ren_cyc.size(); i++) begin
         chk($sformatf("%s_rcyc%0d", nm, i), ren_cyc[i], k + exp_rel[i]);
         chk($sformatf("%s_vec%0d", nm, i), ren_vec[i], (vb + i % nw) % AMOD);
         chk($sformatf("%s_mat%0d", nm, i), ren_mat[i], (mb + i) % AMOD);
      end
      chk({nm, "_ntag"}, tag_cyc.size(), n);
      for (int i = 0; i < n && i < tag_cyc.size(); i++) begin
         chk($sformatf("%s_tcyc%0d", nm, i), tag_cyc[i], k + exp_rel[i] + PIPE_LAT);
         chk($sformatf("%s_first%0d", nm, i), tag_f[i], int'(i % nw == 0));
         chk($sformatf("%s_last%0d", nm, i), tag_l[i], int'(i % nw == nw - 1));
      end
      chk({nm, "_ndone"}, done_n, 1);
      chk({nm, "_done_cyc"}, done_cyc, k + exp_rel[n-1] + PIPE_LAT + 1);
      chk({nm, "_done_busy"}, done_busy, 0);
      chk({nm, "_busy_k1"}, int'(busy_h[(k + 1) % 4096]), 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      vec_base = '0; mat_base = '0; num_words = '0; num_rows = '0;
      repeat (3) @(negedge clk);
      chk("rst_ren",    int'(mem_ren), 0);
      chk("rst_ivalid", int'(accum_ivalid), 0);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_done",   int'(done), 0);
      chk("rst_mat",    int'(mat_raddr), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic 3x2 sequence
      do_cmd(0, 16, 3, 2, 0, 0, 0, -1, 20);
      exp_rel = '{2, 3, 4, 5, 6, 7};
      check_seq("basic", 0, 16, 3, 2);
`ifdef ACCUM_SEQ_CTRL_PERF_EN
      chk("basic_perf_busy", int'(perf_busy_cycles), 10);
      chk("basic_perf_stall", int'(perf_stall_cycles), 0);
`endif

      // Single word per row; start re-pulsed while busy with new config
      do_cmd(5, 40, 1, 4, 0, 0, 3, -1, 20);
      exp_rel = '{2, 3, 4, 5};
      check_seq("nw1", 5, 40, 1, 4);

      // Stall for 3 ISSUE cycles after the second read
      do_cmd(8, 16, 4, 1, 3, 3, 0, -1, 20);
      exp_rel = '{2, 3, 7, 8};
      check_seq("stall", 8, 16, 4, 1);
      chk("stall_mat_hold", mat_h[(k + 5) % 4096], 17);
      chk("stall_vec_hold", vec_h[(k + 5) % 4096], 9);
      chk("stall_busy",     int'(busy_h[(k + 5) % 4096]), 1);
`ifdef ACCUM_SEQ_CTRL_PERF_EN
      chk("stall_perf_busy", int'(perf_busy_cycles), 11);
      chk("stall_perf_stall", int'(perf_stall_cycles), 3);
`endif

      // Zero-length command
      do_cmd(0, 16, 3, 0, 0, 0, 0, -1, 10);
      chk("zero_nren",     ren_cyc.size(), 0);
      chk("zero_ntag",     tag_cyc.size(), 0);
      chk("zero_ndone",    done_n, 1);
      chk("zero_done_cyc", done_cyc, k + 2);
      chk("zero_busy_k1",  int'(busy_h[(k + 1) % 4096]), 0);

      // Reset after two of six reads
      do_cmd(0, 16, 3, 2, 0, 0, 0, 3, 20);
      chk("rstmid_nren",  ren_cyc.size(), 2);
      chk("rstmid_quiet", int'(any_h[(k + 4) % 4096]), 0);
      chk("rstmid_ntag",  tag_cyc.size(), 0);
      chk("rstmid_ndone", done_n, 0);

      // Full sequence after the reset
      do_cmd(0, 16, 3, 2, 0, 0, 0, -1, 20);
      exp_rel = '{2, 3, 4, 5, 6, 7};
      check_seq("after_rst", 0, 16, 3, 2);

      // Matrix address wrap
      do_cmd(3, 510, 2, 2, 0, 0, 0, -1, 20);
      exp_rel = '{2, 3, 4, 5};
      check_seq("wrap", 3, 510, 2, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
